// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver:
//   - uart_state_e : frame FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   - OVERSAMPLE   : baud ticks per bit
//   - PARITY_*     : parity mode selectors
//   - clogb2       : ceiling log2, never smaller than 1
//   - calc_parity  : parity bit for a data word under a given parity mode
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE  = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Ceiling log2; a value of 1 still needs one bit to be stored.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

    // Parity bit for up to 16 data bits; zero-extension leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [15:0] data, input int mode);
        logic result;
        case (mode)
            PARITY_EVEN: result = ^data;
            PARITY_ODD:  result = ~^data;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Serialises one NB_DATA-bit word per accepted request into
//   start bit, data bits LSB first, optional parity bit and a stop period, timed
//   by an external 16x oversampling baud tick shared with the receiver.
//
//   Parameters
//     NB_DATA  data bits per frame (1..16)
//     NB_STOP  stop duration in ticks (16 = 1 bit, 24 = 1.5, 32 = 2)
//     PARITY   0 none, 1 even, 2 odd
//
//   Ports
//     clk         system clock, rising edge
//     i_rst       synchronous reset, active high
//     i_tick      baud tick, one clk wide, 16 per bit
//     i_tx_start  send request, honoured only while idle
//     i_data      word captured on the accepted request
//     o_tx        serial line, idles high
//     o_busy      high while a frame is in flight
//     o_txdone    one-clk pulse when the frame completes
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 16,
    parameter int PARITY  = 0
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_txdone
);

    localparam int NB_TICK   = clogb2((NB_STOP > OVERSAMPLE) ? NB_STOP : OVERSAMPLE);
    localparam int NB_BITCNT = clogb2(NB_DATA);

    localparam logic [NB_TICK-1:0]   TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
    localparam logic [NB_TICK-1:0]   STOP_LAST = NB_TICK'(NB_STOP - 1);
    localparam logic [NB_BITCNT-1:0] BIT_LAST  = NB_BITCNT'(NB_DATA - 1);

    uart_state_e          state_q,    state_d;
    logic [NB_TICK-1:0]   tick_cnt_q, tick_cnt_d;
    logic [NB_BITCNT-1:0] bit_cnt_q,  bit_cnt_d;
    logic [NB_DATA-1:0]   shift_q,    shift_d;
    logic                 par_q,      par_d;
    logic                 tx_q,       tx_d;
    logic                 busy_q,     busy_d;
    logic                 txdone_q,   txdone_d;

    // State, counter, shift and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            txdone_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            txdone_q   <= txdone_d;
        end
    end

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_d    = ST_START;
                    shift_d    = i_data;
                    par_d      = calc_parity(16'(i_data), PARITY);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + NB_TICK'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + NB_BITCNT'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + NB_TICK'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + NB_TICK'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + NB_TICK'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                shift_d    = '0;
                par_d      = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered line changes on the
    // same edge as the state; this keeps the accept-to-start-bit latency at one
    // clock and leaves exactly one idle-high clock between back-to-back frames.
    always_comb begin
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        case (state_d)
            ST_IDLE:   begin tx_d = 1'b1;       busy_d = 1'b0; end
            ST_START:  begin tx_d = 1'b0;       busy_d = 1'b1; end
            ST_DATA:   begin tx_d = shift_d[0]; busy_d = 1'b1; end
            ST_PARITY: begin tx_d = par_d;      busy_d = 1'b1; end
            ST_STOP:   begin tx_d = 1'b1;       busy_d = 1'b1; end
            default:   begin tx_d = 1'b1;       busy_d = 1'b0; end
        endcase
        txdone_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    assign o_tx     = tx_q;
    assign o_busy   = busy_q;
    assign o_txdone = txdone_q;

endmodule
